pdm_cic_decimator: RTL and testbench
====================================

// Module: pdm_cic_decimator
// PURPOSE
//  Front end of the mic-array pipeline; sits directly upstream of the beamformer.
//  Generates the shared PDM clock for all mics and samples one PDM data line per mic.
//  Decimates each bitstream with a 3rd-order CIC to PCM, emitting one BIT_WIDTH
//  offset-binary sample per mic per frame; output feeds beamformer pcm_data_in.
// PARAMETERS
//  NUM_MICS     9   number of mic channels (one PDM data pin each)
//  BIT_WIDTH    8   PCM output width per mic (offset binary)
//  LOG2_DECIM   6   log2 of decimation ratio R (R=64)
//  PDM_CLK_DIV  16  clk cycles per pdm_clk_out half-period (>=2)
// PORTS
//  clk           in   1                      system clock
//  rst_n         in   1                      async active-low reset
//  pdm_data_in   in   NUM_MICS               raw PDM bits, one per mic (async to clk)
//  pdm_clk_out   out  1                      PDM clock to all mics
//  pcm_data_out  out  BIT_WIDTH x NUM_MICS   unpacked array [0:NUM_MICS-1], decimated PCM
//  pcm_valid     out  1                      1-cycle strobe: new frame on pcm_data_out
//  pcm_busy      out  1                      high while comb FSM is running
// BEHAVIOUR
//  Reset (rst_n low, async): pdm_clk_out=0, pcm_valid=0, pcm_busy=0, all
//   pcm_data_out=8'h80 (mid-scale), integrators/combs/counters/FSM cleared to 0/IDLE.
//   Deassertion is synchronised internally (2-flop) before release.
//  PDM clock: divider counts 0..PDM_CLK_DIV-1, toggles pdm_clk_out at terminal count.
//   First rising edge of pdm_clk_out occurs PDM_CLK_DIV clks after reset release.
//  Input: pdm_data_in passes a 2-flop synchroniser. Sample strobe fires in the clk
//   cycle where pdm_clk_out toggles 1->0; synced bit b maps to x=+1 (b=1) / -1 (b=0).
//  Integrators: 3 cascaded per mic at PDM rate, ACC_W = 3*LOG2_DECIM+2 (=20) bits
//   signed; two's-complement wrap is intentional and must NOT be saturated.
//  Decimation counter: 0..2^LOG2_DECIM-1 on each sample strobe; at wrap the
//   final integrator outputs of all mics are latched into a snapshot bank and FSM starts.
//  FSM (comb stage, time-multiplexed, one mic per clk):
//   IDLE  : wait for snapshot; -> COMB, mic_idx=0, pcm_busy=1.
//   COMB  : 3 cascaded combs (y=x-x_prev, 1-sample delay per mic) on mic_idx;
//           result written to staging reg; mic_idx++; at NUM_MICS-1 -> UPDATE.
//   UPDATE: copy all staging regs to pcm_data_out together; pcm_valid=1 for 1 clk;
//           pcm_busy=0; -> IDLE.
//  Latency: snapshot -> pcm_valid = NUM_MICS+1 clks; FSM always finishes well before
//   next snapshot (requires NUM_MICS+2 < 2*PDM_CLK_DIV*2^LOG2_DECIM; checked by assertion).
//  Snapshot arriving while not IDLE (illegal config): snapshot overwritten, frame dropped,
//   FSM not restarted; flagged by simulation assertion.
//  Scaling: comb result range [-2^18,+2^18]. Saturate +2^18 to 2^18-1, take bits
//   [18:18-BIT_WIDTH+1] (signed), invert MSB -> offset binary. All-ones -> 8'hFF,
//   all-zeros -> 8'h00, 50% density -> 8'h80.
//  Outputs only change in UPDATE; pcm_data_out is stable for a whole frame.
//  First 3 frames after reset are CIC warm-up and are emitted (not suppressed).
// CONFIGURATION
//  DC_BLOCK_EN defined: per-mic 1-pole high-pass after scaling, in COMB cycle:
//   y = x - x_prev + y_prev - (y_prev>>>8), signed BIT_WIDTH+8 internal, saturated
//   to BIT_WIDTH before offset conversion; constant input decays toward 8'h80.
//   Latency unchanged (same cycle). State reset to 0.
//  DC_BLOCK_EN undefined: scaled CIC output passed straight through; no extra regs.
// TESTING
//  Reset, then count clks: pdm_clk_out period = 2*PDM_CLK_DIV=32 clks; pcm_valid
//   period = 32*64=2048 clks; pcm_busy high exactly NUM_MICS clks before each strobe.
//  All mics constant 1 -> from 4th pcm_valid on, every pcm_data_out = 8'hFF;
//   constant 0 -> 8'h00; alternating 1/0 -> 8'h80 (+/-1 LSB).
//  Mic k=4 constant 1, others alternating -> only pcm_data_out[4]=8'hFF, rest 8'h80
//   (channel independence, correct index ordering).
//  Assert rst_n low mid-COMB -> outputs immediately 8'h80, pcm_valid=0, pcm_busy=0;
//   after release, first pcm_valid at 2048 clks (+sync/latency), no stale data.
//  Run 10^6 clks of random 75%-density PDM -> no X, integrators wrap, output
//   settles at 8'hBF/8'hC0 (integrator wrap correctness).
//  DC_BLOCK_EN build: constant 1 input -> output steps high, then decays to 8'h80
//   within 2000 frames; without macro remains 8'hFF.

Source files
------------

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: shared PDM clock generator + per-mic 3rd-order CIC decimator.
// Each mic's integrators run at the PDM rate. The comb stage is time-multiplexed,
// handling one mic per clk, and emits one offset-binary frame per decimation period.
// Optional build macro: DC_BLOCK_EN adds a per-mic 1-pole high-pass after scaling.

// Per-mic front end: input synchroniser and three cascaded integrators.
module pdm_cic_integ #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pdm_i,
  input  logic                    stb_i,
  output logic [ACC_W-1:0]        acc_o
);
  logic [1:0]              sync_q;
  logic signed [ACC_W-1:0] x;
  logic signed [ACC_W-1:0] i1_q, i2_q, i3_q;

  // Synced bit 1 -> +1, 0 -> -1.
  assign x     = sync_q[1] ? ACC_W'(1) : {ACC_W{1'b1}};
  assign acc_o = i3_q;

  // Two-flop synchroniser for the asynchronous PDM line.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pdm_i};

  // Registered integrator cascade. Wrap-around is intentional, and the combs undo it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
      i3_q <= '0;
    end else if (stb_i) begin
      i1_q <= i1_q + x;
      i2_q <= i2_q + i1_q;
      i3_q <= i3_q + i2_q;
    end
endmodule

module pdm_cic_decimator #(
  parameter int NUM_MICS    = 9,
  parameter int BIT_WIDTH   = 8,
  parameter int LOG2_DECIM  = 6,
  parameter int PDM_CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_MICS-1:0]  pdm_data_in,
  output logic                 pdm_clk_out,
  output logic [BIT_WIDTH-1:0] pcm_data_out [0:NUM_MICS-1],
  output logic                 pcm_valid,
  output logic                 pcm_busy
);
  localparam int ACC_W = 3*LOG2_DECIM + 2;
  localparam int DIV_W = (PDM_CLK_DIV > 1) ? $clog2(PDM_CLK_DIV) : 1;
  localparam int IDX_W = (NUM_MICS > 1) ? $clog2(NUM_MICS) : 1;
  localparam logic [BIT_WIDTH-1:0] MID = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, COMB, UPDATE} state_t;
  typedef struct packed {
    logic [ACC_W-1:0] d1;
    logic [ACC_W-1:0] d2;
    logic [ACC_W-1:0] d3;
  } comb_st_t;

  // ---------------- reset synchroniser ----------------
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // Assert asynchronously, release two clks later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};

  assign rst_int_n = rst_sync_q[1];

  // ---------------- PDM clock divider ----------------
  logic [DIV_W-1:0] div_q;
  logic             pdm_clk_q;
  logic             div_tc, smp_stb;

  assign div_tc      = (div_q == DIV_W'(PDM_CLK_DIV-1));
  assign smp_stb     = div_tc & pdm_clk_q;  // cycle where pdm_clk goes 1->0
  assign pdm_clk_out = pdm_clk_q;

  // Half-period counter that toggles the shared PDM clock.
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      div_q <= div_tc ? '0 : div_q + 1'b1;
      if (div_tc) pdm_clk_q <= ~pdm_clk_q;
    end

  // ---------------- per-mic integrators ----------------
  logic [NUM_MICS-1:0][ACC_W-1:0] acc;

  for (genvar m = 0; m < NUM_MICS; m++) begin : g_mic
    pdm_cic_integ #(.ACC_W(ACC_W)) u_integ (
      .clk   (clk),
      .rst_n (rst_int_n),
      .pdm_i (pdm_data_in[m]),
      .stb_i (smp_stb),
      .acc_o (acc[m])
    );
  end

  // ---------------- decimation counter + snapshot ----------------
  logic [LOG2_DECIM-1:0]          dec_q;
  logic                           snap_fire;
  logic [NUM_MICS-1:0][ACC_W-1:0] snap_q;

  assign snap_fire = smp_stb & (&dec_q);

  // Count PDM samples. At wrap, latch every mic's final integrator.
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      dec_q  <= '0;
      snap_q <= '0;
    end else begin
      if (smp_stb)   dec_q  <= dec_q + 1'b1;
      if (snap_fire) snap_q <= acc;
    end

  // ---------------- comb FSM ----------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d, valid_q, valid_d;
  logic             comb_we, out_we;

  // Sequence: start on snapshot, one mic per clk, then publish the frame.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    comb_we = 1'b0;
    out_we  = 1'b0;
    case (state_q)
      IDLE: if (snap_fire) begin
        state_d = COMB;
        idx_d   = '0;
        busy_d  = 1'b1;
      end
      COMB: begin
        comb_we = 1'b1;
        if (idx_q == IDX_W'(NUM_MICS-1)) begin
          state_d = UPDATE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      UPDATE: begin
        out_we  = 1'b1;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, mic index and status strobes.
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end

  assign pcm_busy  = busy_q;
  assign pcm_valid = valid_q;

  // ---------------- comb datapath + scaling ----------------
  comb_st_t [NUM_MICS-1:0]         cst_q;
  logic signed [ACC_W-1:0]         cx, c1, c2, c3, csat;
  logic signed [BIT_WIDTH-1:0]     cic_s, pcm_s;
  logic [BIT_WIDTH-1:0]            pcm_ob;
  localparam logic signed [ACC_W-1:0] SAT_HI = {2'b00, {(ACC_W-2){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {2'b11, {(ACC_W-2){1'b0}}};

  // Three combs on the selected mic. The result saturates to the top of the range and is then truncated.
  always_comb begin
    cx    = $signed(snap_q[idx_q]);
    c1    = cx - $signed(cst_q[idx_q].d1);
    c2    = c1 - $signed(cst_q[idx_q].d2);
    c3    = c2 - $signed(cst_q[idx_q].d3);
    csat  = (c3 > SAT_HI) ? SAT_HI : (c3 < SAT_LO) ? SAT_LO : c3;
    cic_s = csat[ACC_W-2 -: BIT_WIDTH];
  end

`ifdef DC_BLOCK_EN
  localparam int HP_W = BIT_WIDTH + 8;
  localparam logic signed [HP_W+1:0] HP_HI = (HP_W+2)'((1 << (HP_W-1)) - 1);
  localparam logic signed [HP_W+1:0] HP_LO = -(HP_W+2)'(1 << (HP_W-1));
  logic [NUM_MICS-1:0][HP_W-1:0] hx_q, hy_q;
  logic signed [HP_W-1:0]        hx_new, hx_prev, hy_prev, hy_new;
  logic signed [HP_W+1:0]        hp_sum;

  // The high-pass runs with 8 fractional bits so that the y>>>8 leak is effective.
  always_comb begin
    hx_new  = {cic_s, {8{1'b0}}};
    hx_prev = hx_q[idx_q];
    hy_prev = hy_q[idx_q];
    hp_sum  = (HP_W+2)'(hx_new) - (HP_W+2)'(hx_prev)
            + (HP_W+2)'(hy_prev) - (HP_W+2)'(hy_prev >>> 8);
    hy_new  = (hp_sum > HP_HI) ? HP_HI[HP_W-1:0] :
              (hp_sum < HP_LO) ? HP_LO[HP_W-1:0] : hp_sum[HP_W-1:0];
    pcm_s   = hy_new[HP_W-1 -: BIT_WIDTH];
  end

  // Per-mic high-pass history, advanced in the mic's comb cycle.
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      hx_q <= '0;
      hy_q <= '0;
    end else if (comb_we) begin
      hx_q[idx_q] <= hx_new;
      hy_q[idx_q] <= hy_new;
    end
`else
  assign pcm_s = cic_s;
`endif

  assign pcm_ob = {~pcm_s[BIT_WIDTH-1], pcm_s[BIT_WIDTH-2:0]};

  // Comb delay lines and staging register for the mic being processed.
  logic [NUM_MICS-1:0][BIT_WIDTH-1:0] stg_q;
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      cst_q <= '0;
      stg_q <= '0;
    end else if (comb_we) begin
      cst_q[idx_q].d1 <= cx;
      cst_q[idx_q].d2 <= c1;
      cst_q[idx_q].d3 <= c2;
      stg_q[idx_q]    <= pcm_ob;
    end

  // All channels publish together, so the output holds for a whole frame.
  logic [NUM_MICS-1:0][BIT_WIDTH-1:0] out_q;
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) out_q <= {NUM_MICS{MID}};
    else if (out_we) out_q <= stg_q;

  for (genvar m = 0; m < NUM_MICS; m++) begin : g_out
    assign pcm_data_out[m] = out_q[m];
  end

  // ---------------- assertions ----------------
  a_cfg_fits: assert property (@(posedge clk)
    (NUM_MICS + 2) < (2 * PDM_CLK_DIV * (2 ** LOG2_DECIM)));
  a_snap_idle: assert property (@(posedge clk) disable iff (!rst_int_n)
    snap_fire |-> (state_q == IDLE));
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator with hand-computed frame values.
module tb_pdm_cic_decimator;
  localparam int NM = 9;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] pdm_data_in;
  logic          pdm_clk_out, pcm_valid, pcm_busy;
  logic [BW-1:0] pcm_data_out [0:NM-1];
  logic [NM-1:0] cmask, amask;
  logic          alt = 1'b0;
  int            total = 0, bad = 0;
  int            cyc = 0, busy_n, c0, c1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge pdm_clk_out) alt = ~alt;
  assign pdm_data_in = cmask | (amask & {NM{alt}});

  pdm_cic_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pdm_data_in  (pdm_data_in),
    .pdm_clk_out  (pdm_clk_out),
    .pcm_data_out (pcm_data_out),
    .pcm_valid    (pcm_valid),
    .pcm_busy     (pcm_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    logic got = 1'b0;
    busy_n = 0;
    for (int b = 0; b < 4000 && !got; b++) begin
      @(negedge clk);
      if (pcm_busy)  busy_n++;
      if (pcm_valid) got = 1'b1;
    end
    if (!got) chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_rise(input string tag);
    logic got = 1'b0;
    logic prev;
    prev = pdm_clk_out;
    for (int b = 0; b < 200 && !got; b++) begin
      @(negedge clk);
      if (!prev && pdm_clk_out) got = 1'b1;
      prev = pdm_clk_out;
    end
    if (!got) chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
  endtask

  task automatic chk_all(input string tag, input logic [BW-1:0] exp);
    for (int m = 0; m < NM; m++)
      chk($sformatf("%s[%0d]", tag, m), 32'(pcm_data_out[m]), 32'(exp));
  endtask

  initial begin
    cmask = '1;
    amask = '0;
    repeat (5) @(negedge clk);
    chk("rst_pdmclk", 32'(pdm_clk_out), 32'd0);
    chk("rst_valid",  32'(pcm_valid),   32'd0);
    chk("rst_busy",   32'(pcm_busy),    32'd0);
    chk_all("rst_data", 8'h80);

    // Release. The PDM clock rises 16 clks after the internal release, which adds 2 sync clks.
    rst_n = 1'b1;
    c0 = cyc;
    wait_rise("rise1");
    chk("pdm_first_rise", cyc - c0, 32'd18);
    c1 = cyc;
    wait_rise("rise2");
    chk("pdm_period", cyc - c1, 32'd32);

    // Frame 1: snapshot at edge 2+32*64, valid 10 clks later; C(63,3)=39711 -> 0x13 -> 0x93.
    wait_valid("v1");
    chk("v1_latency", cyc - c0, 32'd2060);
    chk("busy_len", busy_n, 32'd9);
    chk_all("f1_const1", 8'h93);
    // Frame 2: comb result 214242 -> 0x68 -> 0xE8.
    c1 = cyc;
    wait_valid("v2");
    chk("valid_period", cyc - c1, 32'd2048);
    chk("busy_len2", busy_n, 32'd9);
    chk_all("f2_const1", 8'hE8);
    repeat (2) wait_valid("v34");
    chk_all("const1", 8'hFF);

    cmask = '0;
    repeat (4) wait_valid("c0");
    chk_all("const0", 8'h00);

    amask = '1;
    repeat (4) wait_valid("alt");
    chk_all("alternating", 8'h80);

    cmask = 9'h010;
    amask = ~9'h010;
    repeat (4) wait_valid("mix");
    for (int m = 0; m < NM; m++)
      chk($sformatf("mic4_only[%0d]", m), 32'(pcm_data_out[m]), (m == 4) ? 32'hFF : 32'h80);

    // Reset during COMB: outputs clear at once, and the next frame is fresh warm-up data.
    cmask = '1;
    amask = '0;
    for (int b = 0; b < 3000 && !pcm_busy; b++) @(negedge clk);
    chk("busy_seen", 32'(pcm_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(pcm_valid), 32'd0);
    chk("midrst_busy",  32'(pcm_busy),  32'd0);
    chk("midrst_pdm",   32'(pdm_clk_out), 32'd0);
    chk_all("midrst_data", 8'h80);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    c0 = cyc;
    wait_valid("rv1");
    chk("rst_v1_latency", cyc - c0, 32'd2060);
    chk_all("rst_f1", 8'h93);
    wait_valid("rv2");
    chk_all("rst_f2", 8'hE8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
